// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem fetches and loads IF/ID.
// Branch/jump redirects use MIPS delay-slot semantics and survive imem wait states.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] rsData,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pcPlus4,
  output logic        if_id_valid
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]  state, stateNext;
  logic [31:0] pc, pcNext, pcPlus4;
  logic [31:0] pendTarget, pendTargetNext;
  logic [31:0] instrNext, pcPlus4Next;
  logic        validNext;
  logic        fetchDone, idAdvance, redirect;
  logic [31:0] jrTarget, jumpTarget, branchTarget, target;
  logic [31:0] branchOffset;

  assign imem_addr = pc;
  assign pcPlus4   = pc + 32'd4;

  assign fetchDone = imem_ready & imem_req & ~stall;
  assign idAdvance = ~stall;
  assign redirect  = if_id_valid & idAdvance & (JumpReg | Jump | branchTaken);

  assign jrTarget     = rsData & 32'hFFFF_FFFC;
  assign jumpTarget   = {if_id_pcPlus4[31:28], if_id_instr[25:0], 2'b00};
  assign branchOffset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
  assign branchTarget = if_id_pcPlus4 + branchOffset;

  always_comb begin
    target = branchTarget;
    if (JumpReg)   target = jrTarget;
    else if (Jump) target = jumpTarget;
  end

  // A redirect seen while the delay slot is still waiting on imem is parked
  // in pendTarget and applied on the delay slot's completing fetch.
  always_comb begin
    pcNext         = pc;
    stateNext      = state;
    pendTargetNext = pendTarget;
    instrNext      = if_id_instr;
    pcPlus4Next    = if_id_pcPlus4;
    validNext      = if_id_valid;
    if (!stall) begin
      if (fetchDone) begin
        instrNext   = imem_rdata;
        pcPlus4Next = pcPlus4;
        validNext   = 1'b1;
        if (redirect) begin
          pcNext = target;
        end else if (state == PEND) begin
          pcNext    = pendTarget;
          stateNext = RUN;
        end else begin
          pcNext = pcPlus4;
        end
      end else begin
        instrNext   = '0;
        pcPlus4Next = '0;
        validNext   = 1'b0;
        if (redirect) begin
          pendTargetNext = target;
          stateNext      = PEND;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      state         <= RUN;
      pendTarget    <= '0;
      imem_req      <= 1'b0;
      if_id_instr   <= '0;
      if_id_pcPlus4 <= '0;
      if_id_valid   <= 1'b0;
    end else begin
      pc            <= pcNext;
      state         <= stateNext;
      pendTarget    <= pendTargetNext;
      imem_req      <= 1'b1;
      if_id_instr   <= instrNext;
      if_id_pcPlus4 <= pcPlus4Next;
      if_id_valid   <= validNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for straight-line, branch, wait,
// stall and jump-priority behaviour, plus a hand sequence for reset during PEND.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branchTaken, Jump, JumpReg;
  logic [31:0] rsData, imem_rdata;
  logic        imem_ready;
  logic [31:0] imem_addr, if_id_instr, if_id_pcPlus4;
  logic        imem_req, if_id_valid;

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branchTaken(branchTaken),
    .Jump(Jump), .JumpReg(JumpReg), .rsData(rsData),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_instr(if_id_instr),
    .if_id_pcPlus4(if_id_pcPlus4), .if_id_valid(if_id_valid)
  );

  typedef struct {
    logic        stall, br, j, jr;
    logic [31:0] rs;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] eAddr, eInstr, ePc4;
    logic        eValid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I100 = 32'h1111_0100;
  localparam logic [31:0] I104 = 32'h1000_FFFE; // beq, imm -2
  localparam logic [31:0] I108 = 32'h3333_0108;
  localparam logic [31:0] I2000 = 32'h4444_2000;
  localparam logic [31:0] I3FFF8 = 32'h5555_0000;

  function automatic vec_t mk(logic s, logic b, logic j, logic jr, logic [31:0] rs,
                              logic rdy, logic [31:0] rd, logic [31:0] ea,
                              logic [31:0] ei, logic [31:0] ep, logic ev);
    vec_t v;
    v.stall = s; v.br = b; v.j = j; v.jr = jr; v.rs = rs; v.rdy = rdy; v.rdata = rd;
    v.eAddr = ea; v.eInstr = ei; v.ePc4 = ep; v.eValid = ev;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic s, logic b, logic j, logic jr, logic [31:0] rs,
                       logic rdy, logic [31:0] rd);
    stall = s; branchTaken = b; Jump = j; JumpReg = jr; rsData = rs;
    imem_ready = rdy; imem_rdata = rd;
  endtask

  initial begin
    //            st br j jr rs            rdy rdata   addr           instr  pc4            valid
    vecs.push_back(mk(0,0,0,0,32'h0,      1, 32'hDEAD_BEEF, 32'h100, 32'h0, 32'h0,   0)); // req rises, no fetch yet
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I100,    32'h104,  I100,  32'h104,  1));
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I104,    32'h108,  I104,  32'h108,  1));
    vecs.push_back(mk(0,1,0,0,32'h0,      1, I108,    32'h100,  I108,  32'h10C,  1)); // branch + delay slot
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I100,    32'h104,  I100,  32'h104,  1));
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I104,    32'h108,  I104,  32'h108,  1));
    vecs.push_back(mk(0,1,0,0,32'h0,      0, 32'h0,   32'h108,  32'h0, 32'h0,    0)); // enter PEND
    vecs.push_back(mk(0,1,0,0,32'h0,      0, 32'h0,   32'h108,  32'h0, 32'h0,    0));
    vecs.push_back(mk(0,0,0,0,32'h0,      0, 32'h0,   32'h108,  32'h0, 32'h0,    0));
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I108,    32'h100,  I108,  32'h10C,  1)); // delay slot, then target
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I100,    32'h104,  I100,  32'h104,  1));
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I104,    32'h108,  I104,  32'h108,  1));
    vecs.push_back(mk(1,1,0,0,32'h0,      1, I108,    32'h108,  I104,  32'h108,  1)); // stall holds
    vecs.push_back(mk(1,1,0,0,32'h0,      1, I108,    32'h108,  I104,  32'h108,  1));
    vecs.push_back(mk(0,1,0,0,32'h0,      1, I108,    32'h100,  I108,  32'h10C,  1));
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I100,    32'h104,  I100,  32'h104,  1));
    vecs.push_back(mk(0,1,1,1,32'h2003,   1, I104,    32'h2000, I104,  32'h108,  1)); // JR wins, low bits masked
    vecs.push_back(mk(0,1,1,0,32'h0,      1, I2000,   32'h3FFF8,I2000, 32'h2004, 1)); // J beats branch
    vecs.push_back(mk(0,0,0,0,32'h0,      1, I3FFF8,  32'h3FFFC,I3FFF8,32'h3FFFC,1));

    drive(0, 0, 0, 0, 32'h0, 1, 32'h0);
    rst_n = 1'b0;
    #12;
    check("reset_addr",   imem_addr, 32'h100);
    check("reset_req",    {31'b0, imem_req}, 32'h0);
    check("reset_instr",  if_id_instr, 32'h0);
    check("reset_pc4",    if_id_pcPlus4, 32'h0);
    check("reset_valid",  {31'b0, if_id_valid}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].j, vecs[i].jr, vecs[i].rs,
            vecs[i].rdy, vecs[i].rdata);
      @(posedge clk); #1;
      check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].eAddr);
      check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].eInstr);
      check($sformatf("v%0d_pc4", i),   if_id_pcPlus4, vecs[i].ePc4);
      check($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].eValid});
      check($sformatf("v%0d_req", i),   {31'b0, imem_req}, 32'h1);
    end

    // JR redirect while imem waits -> PEND with target 0x8000, then reset drops it
    drive(0, 0, 0, 1, 32'h0000_8000, 0, 32'h0);
    @(posedge clk); #1;
    check("pend_addr",  imem_addr, 32'h3FFFC);
    check("pend_valid", {31'b0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_addr",  imem_addr, 32'h100);
    check("midrst_req",   {31'b0, imem_req}, 32'h0);
    check("midrst_valid", {31'b0, if_id_valid}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 1, I100);
    @(posedge clk); #1;
    check("restart_addr0", imem_addr, 32'h100);
    @(posedge clk); #1;
    check("restart_addr1", imem_addr, 32'h104);
    check("restart_instr", if_id_instr, I100);
    drive(0, 0, 0, 0, 32'h0, 1, I104);
    @(posedge clk); #1;
    check("restart_addr2", imem_addr, 32'h108);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
